ascii_uart_tx: RTL

Downstream consumer of the binary-to-BCD/ASCII converter. Latches its 4-character ASCII word when the converter's ready flag rises, then serialises the characters as UART 8N1 frames on a single TX line. Drives cross_ready back to the converter, freezing it while a transmission is in flight. Sits between the converter and the board UART pin.

---
 rtl/ascii_uart_pkg.sv | 16 +
 rtl/uart_tx_byte.sv | 101 ++++++++++
 rtl/ascii_uart_tx.sv | 93 +++++++++
 3 files changed

// File: rtl/ascii_uart_pkg.sv
// Shared types and constants for the ASCII UART transmitter.
// The ASCII_CRLF_EN macro (used in ascii_uart_tx) appends CR/LF frames to each message.
package ascii_uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA      = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser. A start offered in the last stop-bit cycle chains
// the next frame with no idle gap between frames.
module uart_tx_byte
    import ascii_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    data_q, data_n;
    logic          tx_n;
    logic          term;

    assign term = (baud == BAUD_LAST);

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        data_n  = data_q;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = START_BIT;
                    baud_n  = '0;
                    data_n  = data;
                end
            end
            START_BIT: begin
                if (term) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (term) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) state_n = STOP_BIT;
                    else                 bit_n   = bit_idx + 3'd1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP_BIT: begin
                if (term) begin
                    done   = 1'b1;
                    baud_n = '0;
                    if (start) begin
                        state_n = START_BIT;
                        data_n  = data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next state so the pin never glitches
        case (state_n)
            START_BIT: tx_n = 1'b0;
            DATA:      tx_n = data_n[bit_n];
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            data_q  <= 8'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            data_q  <= data_n;
            tx      <= tx_n;
        end
    end

endmodule

// File: rtl/ascii_uart_tx.sv
// Captures a 4-char ASCII word on a bcd_ready rising edge and sends it as 8N1 frames.
// Define ASCII_CRLF_EN to follow each message with CR and LF frames.
module ascii_uart_tx
    import ascii_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CHARS    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_CHARS-1:0] ascii_in,
    input  logic                   bcd_ready,
    output logic                   cross_ready,
    output logic                   tx,
    output logic                   busy
);

`ifdef ASCII_CRLF_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    logic                   bcd_ready_d;
    logic                   capture;
    logic [8*NUM_CHARS-1:0] char_buf;
    logic [2:0]             char_idx;
    logic                   byte_start;
    logic [7:0]             byte_data;
    logic                   byte_done;

    function automatic logic [7:0] char_at(input logic [31:0] word, input logic [2:0] idx);
        case (idx)
            3'd0:    return word[31:24];
            3'd1:    return word[23:16];
            3'd2:    return word[15:8];
`ifdef ASCII_CRLF_EN
            3'd4:    return ASCII_CR;
            3'd5:    return ASCII_LF;
`endif
            default: return word[7:0];
        endcase
    endfunction

    assign capture = bcd_ready & ~bcd_ready_d;

    // First char comes straight from the input so tx drops on the capture edge
    always_comb begin
        byte_start = 1'b0;
        byte_data  = ascii_in[31:24];
        if (!busy) begin
            byte_start = capture;
        end else begin
            byte_start = byte_done && (char_idx != LAST_IDX);
            byte_data  = char_at(char_buf, char_idx + 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcd_ready_d <= 1'b0;
            char_buf    <= '0;
            char_idx    <= 3'd0;
            busy        <= 1'b0;
        end else begin
            bcd_ready_d <= bcd_ready;
            if (!busy) begin
                if (capture) begin
                    char_buf <= ascii_in;
                    char_idx <= 3'd0;
                    busy     <= 1'b1;
                end
            end else if (byte_done) begin
                if (char_idx == LAST_IDX) busy     <= 1'b0;
                else                      char_idx <= char_idx + 3'd1;
            end
        end
    end

    assign cross_ready = ~busy;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .done  (byte_done)
    );

endmodule
